// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: shared architecture definitions for the computer.
//   ADDR_WIDTH / DATA_WIDTH  : RAM address and data widths.
//   arb_state_t              : RAM port arbiter FSM states.
//   arb_owner_t              : which requester owns an in-flight read.
//   ARB_*_DEFAULT            : default arbiter parameters.
package arch_defs_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 8;

  localparam int ARB_MAX_WAIT_DEFAULT = 4;
  localparam int ARB_LOCK_MAX_DEFAULT = 16;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_LD  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_read_return.sv
// arb_read_return: one-stage owner/valid pipeline that steers the RAM's
// synchronous read data back to whichever requester issued the read.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_gnt_cpu, i_gnt_ld    : grants issued this cycle (mutually exclusive)
//   i_we                   : the granted access is a write
//   i_ram_rdata            : RAM read data (valid the cycle after the address)
//   o_cpu_rvalid/o_cpu_rdata : CPU read return
//   o_ld_rvalid/o_ld_rdata   : loader read return
import arch_defs_pkg::*;

module arb_read_return #(
  parameter int DW = DATA_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_gnt_cpu,
  input  logic          i_gnt_ld,
  input  logic          i_we,
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_ld_rvalid,
  output logic [DW-1:0] o_ld_rdata
);

  logic          r_pend;
  arb_owner_t    r_owner;
  logic [DW-1:0] r_cpu_hold;
  logic [DW-1:0] r_ld_hold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= 1'b0;
      r_owner    <= OWNER_CPU;
      r_cpu_hold <= '0;
      r_ld_hold  <= '0;
    end else begin
      r_pend  <= (i_gnt_cpu || i_gnt_ld) && !i_we;
      r_owner <= i_gnt_ld ? OWNER_LD : OWNER_CPU;
      // Each side keeps the last data it was handed so the non-owner's
      // rdata stays stable while the other side is being served.
      if (o_cpu_rvalid) r_cpu_hold <= i_ram_rdata;
      if (o_ld_rvalid)  r_ld_hold  <= i_ram_rdata;
    end
  end

  assign o_cpu_rvalid = r_pend && (r_owner == OWNER_CPU);
  assign o_ld_rvalid  = r_pend && (r_owner == OWNER_LD);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_ram_rdata : r_cpu_hold;
  assign o_ld_rdata   = o_ld_rvalid  ? i_ram_rdata : r_ld_hold;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port RAM between the CPU (requester 0,
// fixed priority) and the UART debug/load engine (requester 1).
//   clk, reset                    : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_gnt: CPU request and grant
//   cpu_rvalid, cpu_rdata         : CPU read return (cycle after read grant)
//   ld_req/we/addr/wdata, ld_lock : loader request, lock-after-grant request
//   ld_gnt, ld_rvalid, ld_rdata   : loader grant and read return
//   ram_we/addr/wdata, ram_rdata  : RAM port (synchronous read)
//   locked                        : port is locked to the loader
//   dbg_state, dbg_wait_cnt, dbg_lock_cnt : FSM state and counters
//
// Handshake: a requester holds *_req with its command stable; the access is
// consumed in exactly the cycle *_gnt is high (combinational in that cycle).
// For reads, *_rvalid pulses one cycle later with *_rdata; there is no
// backpressure on the read return.
import arch_defs_pkg::*;

module ram_port_arbiter #(
  parameter  int MAX_WAIT = ARB_MAX_WAIT_DEFAULT,
  parameter  int LOCK_MAX = ARB_LOCK_MAX_DEFAULT,
  localparam int WAIT_W   = $clog2(MAX_WAIT) + 1,
  localparam int LOCK_W   = $clog2(LOCK_MAX) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  input  logic                  ld_lock,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  locked,
  output logic                  dbg_state,
  output logic [WAIT_W-1:0]     dbg_wait_cnt,
  output logic [LOCK_W-1:0]     dbg_lock_cnt
);

  localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] C_LOCK_MAX = LOCK_W'(LOCK_MAX);

  arb_state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt, w_wait_nxt;
  logic [LOCK_W-1:0]     r_lock_cnt, w_lock_nxt;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [DATA_WIDTH-1:0] r_last_wdata;
  logic                  w_gnt_cpu;
  logic                  w_gnt_ld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_NORMAL;
      r_wait_cnt   <= '0;
      r_lock_cnt   <= '0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_lock_cnt   <= w_lock_nxt;
      r_last_addr  <= ram_addr;
      r_last_wdata <= ram_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_lock_nxt  = r_lock_cnt;
    w_gnt_cpu   = 1'b0;
    w_gnt_ld    = 1'b0;
    case (r_state)
      ARB_NORMAL: begin
        // CPU wins ties until the loader has waited MAX_WAIT cycles.
        w_gnt_cpu  = cpu_req && (!ld_req || (r_wait_cnt < C_MAX_WAIT));
        w_gnt_ld   = ld_req  && (!cpu_req || (r_wait_cnt == C_MAX_WAIT));
        w_lock_nxt = '0;
        if (!ld_req || w_gnt_ld) begin
          w_wait_nxt = '0;
        end else if (r_wait_cnt != C_MAX_WAIT) begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
        if (w_gnt_ld && ld_lock && (LOCK_MAX > 1)) begin
          w_state_nxt = ARB_LOCKED;
          w_lock_nxt  = LOCK_W'(1);
        end
      end
      ARB_LOCKED: begin
        w_gnt_ld   = ld_req;
        w_wait_nxt = '0;
        // lock_cnt counts every locked cycle (the first grant in NORMAL
        // counts as 1), so an idle lock cannot starve the CPU either.
        // Leaving when the count would reach LOCK_MAX caps the burst at
        // LOCK_MAX cycles including the entry grant.
        if (!ld_lock || (r_lock_cnt >= C_LOCK_MAX - 1'b1)) begin
          w_state_nxt = ARB_NORMAL;
          w_lock_nxt  = '0;
        end else begin
          w_lock_nxt = r_lock_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_NORMAL;
        w_wait_nxt  = '0;
        w_lock_nxt  = '0;
      end
    endcase
    // No grant may be issued while reset is asserted.
    if (!reset) begin
      w_gnt_cpu = 1'b0;
      w_gnt_ld  = 1'b0;
    end
  end

  assign cpu_gnt   = w_gnt_cpu;
  assign ld_gnt    = w_gnt_ld;
  assign ram_we    = (w_gnt_cpu && cpu_we) || (w_gnt_ld && ld_we);
  assign ram_addr  = w_gnt_cpu ? cpu_addr  : (w_gnt_ld ? ld_addr  : r_last_addr);
  assign ram_wdata = w_gnt_cpu ? cpu_wdata : (w_gnt_ld ? ld_wdata : r_last_wdata);

  assign locked       = (r_state == ARB_LOCKED);
  assign dbg_state    = r_state;
  assign dbg_wait_cnt = r_wait_cnt;
  assign dbg_lock_cnt = r_lock_cnt;

  arb_read_return #(
    .DW(DATA_WIDTH)
  ) u_read_return (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_gnt_cpu    (w_gnt_cpu),
    .i_gnt_ld     (w_gnt_ld),
    .i_we         (ram_we),
    .i_ram_rdata  (ram_rdata),
    .o_cpu_rvalid (cpu_rvalid),
    .o_cpu_rdata  (cpu_rdata),
    .o_ld_rvalid  (ld_rvalid),
    .o_ld_rdata   (ld_rdata)
  );

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port RAM between two requesters: the CPU data path (requester 0) and the UART-driven debug/load engine (requester 1).
- Sits between u_cpu/UART loader and u_ram inside computer.
- CPU has fixed priority. A starvation counter guarantees the loader a slot. The loader can lock the port for a burst.
- Read data returns one cycle after grant, matching u_ram's synchronous read.

Parameters:
- MAX_WAIT, 4: consecutive cycles requester 1 may be denied before it is forced a grant (1..15).
- LOCK_MAX, 16: maximum cycles a lock may hold the port before it is forcibly released.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU requests an access this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a read grant).
- cpu_rdata  out  DATA_WIDTH  read data to CPU.
- ld_req  in  1  loader requests an access.
- ld_we  in  1  loader write enable.
- ld_addr  in  ADDR_WIDTH  loader address.
- ld_wdata  in  DATA_WIDTH  loader write data.
- ld_lock  in  1  loader requests to keep ownership after its next grant.
- ld_gnt  out  1  loader access accepted.
- ld_rvalid  out  1  ld_rdata valid.
- ld_rdata  out  DATA_WIDTH  read data to loader.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data (valid cycle after address).
- locked  out  1  status: port is locked to the loader.

Behaviour:
Reset values:
- While reset is low: state ARB_NORMAL; wait_cnt = 0; lock_cnt = 0; all rvalid = 0; locked = 0; ram_we = 0; ram_addr = 0; ram_wdata = 0.
- Reset asserted mid-access drops any pending rvalid; no grant is issued that cycle.

Grants (combinational within the cycle):
- At most one grant per cycle.
- ram_we, ram_addr and ram_wdata are a mux of the granted requester.
- With no grant: ram_we = 0 and ram_addr holds the last value (registered).

ARB_NORMAL:
- cpu_req=1 and (ld_req=0 or wait_cnt < MAX_WAIT): grant CPU.
- ld_req=1 and (cpu_req=0 or wait_cnt == MAX_WAIT): grant loader.
- wait_cnt increments (saturating at MAX_WAIT) when ld_req=1 and the loader is not granted. It clears on a loader grant or when ld_req=0.
- Loader granted with ld_lock=1: next state ARB_LOCKED, lock_cnt = 1.

ARB_LOCKED:
- locked = 1.
- cpu_gnt = 0 unconditionally.
- ld_req=1: grant loader, lock_cnt++.
- Exit to ARB_NORMAL when either of these holds:
  - ld_lock=0 sampled on any cycle;
  - lock_cnt == LOCK_MAX at a clock edge.
- On a forced exit, lock_cnt clears and wait_cnt clears.
- ld_lock must be re-presented with a new grant in ARB_NORMAL to re-lock.

Read return:
- A read grant in cycle N registers owner and read flag.
- In cycle N+1: the owner's rvalid = 1, and its rdata = ram_rdata.
- The non-owner's rdata holds its previous value.
- Writes never produce rvalid.
- Back-to-back grants to alternating owners produce correctly steered rvalid each cycle.

Other rules:
- Write-then-read to the same address in consecutive cycles returns the new data (RAM is write-first; the arbiter adds no forwarding).
- Simultaneous req with wait_cnt == MAX_WAIT: the loader wins, even over the CPU.
- Widths: ADDR_WIDTH and DATA_WIDTH come from arch_defs_pkg. Counters are $clog2(MAX)+1 bits and never wrap.

Decomposition:
- arch_defs_pkg gains:
  - the arb_state_t enum (ARB_NORMAL, ARB_LOCKED);
  - the arb_owner_t enum (OWNER_CPU, OWNER_LD);
  - the localparams ARB_MAX_WAIT_DEFAULT and ARB_LOCK_MAX_DEFAULT.
- One sub-module is natural: arb_read_return, the one-stage owner/valid pipeline that steers ram_rdata.
- Grant logic, counters and the FSM stay in the top module.

Test Plan:
- CPU-only traffic: cpu_req with a write of 0x3C to 0x0020, then a read of 0x0020 -> cpu_gnt both cycles; cpu_rvalid=1 with cpu_rdata=0x3C one cycle after the read; ld_* outputs stay 0.
- Contention: cpu_req and ld_req both held high for 6 cycles, MAX_WAIT=4 -> grant sequence CPU, CPU, CPU, CPU, LD, CPU; wait_cnt returns to 0 after the loader grant.
- Lock burst: loader writes 0x11..0x18 to 0x0100..0x0107 with ld_lock=1 while cpu_req=1 -> locked=1 for 8 cycles, cpu_gnt=0 throughout; CPU is granted on the cycle after ld_lock drops.
- Lock timeout: ld_lock held with continuous ld_req, LOCK_MAX=16 -> exactly 16 loader grants, then locked=0 and the CPU is granted.
- Alternating reads: CPU reads 0x0010 (=0xAA) in cycle N, loader reads 0x0011 (=0x55) in N+1 -> cpu_rvalid/0xAA at N+1, ld_rvalid/0x55 at N+2, no cross-steering.
- Reset mid-lock: reset pulled low during ARB_LOCKED with a read outstanding -> locked=0 and both rvalid=0 immediately (asynchronous); after release, state is ARB_NORMAL and the CPU is granted first.
